// File: rtl/vga_axis_packer_pkg.sv
// Shared video-timing constants, FSM state type and the FIFO beat layout for
// the VGA-to-AXI4-Stream packer.
package starsoc_params;

  localparam int unsigned H_VISIBLE        = 640;
  localparam int unsigned V_VISIBLE        = 480;
  localparam int unsigned VISIBLE_ORIGIN_X = 0;
  localparam int unsigned VISIBLE_ORIGIN_Y = 0;
  localparam int unsigned AXIS_PIX_W       = 24;
  localparam int unsigned COORD_W          = 10;
  localparam int unsigned RGB_W            = 12;

  typedef enum logic [1:0] {
    SYNC_WAIT = 2'd0,
    STREAM    = 2'd1,
    DROP      = 2'd2
  } pack_state_t;

  // One stored pixel: sideband tags travel with the colour data.
  typedef struct packed {
    logic                  tuser;
    logic                  tlast;
    logic [AXIS_PIX_W-1:0] tdata;
  } pix_beat_t;

  // {R4,G4,B4} -> {R8,B8,G8}, each nibble replicated into a byte.
  function automatic logic [AXIS_PIX_W-1:0] expand_rgb444(input logic [RGB_W-1:0] rgb);
    return {rgb[11:8], rgb[11:8], rgb[3:0], rgb[3:0], rgb[7:4], rgb[7:4]};
  endfunction

endpackage

// File: rtl/vga_axis_packer_if.sv
// AXI4-Stream video channel between the packer and the downstream video IP.
interface vga_axis_packer_if;
  import starsoc_params::*;

  logic [AXIS_PIX_W-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tuser;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/vga_axis_packer_fifo.sv
// Show-ahead synchronous FIFO with an occupancy output; a write into a full
// FIFO is accepted only when a read frees a slot in the same cycle.
module axis_sync_fifo #(
  parameter int unsigned WIDTH = 26,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_ok;
  logic             rd_ok;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);

  // Pointers are exactly AW bits wide, so the increment wraps modulo DEPTH.
  always_comb begin
    rd_ok    = rd_en && !empty;
    wr_ok    = wr_en && (!full || rd_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({wr_ok, rd_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
  assign level   = level_q;

endmodule

// File: rtl/vga_axis_packer.sv
// Packs visible VGA pixels into an AXI4-Stream video stream, tagging start of
// frame and end of line, and resynchronising to the next frame after loss.
module vga_axis_packer
  import starsoc_params::*;
#(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter bit          DROP_TO_SOF = 1'b1
) (
  input  logic                        pixel_clk,
  input  logic                        reset,
  input  logic [COORD_W-1:0]          pixel_x,
  input  logic [COORD_W-1:0]          pixel_y,
  input  logic                        video_on,
  input  logic [RGB_W-1:0]            rgb_in,
  vga_axis_packer_if.master           axis,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int unsigned BEAT_W = $bits(pix_beat_t);

  pack_state_t state_q, state_d;
  logic        overflow_q, overflow_d;
  logic        sof_pix;
  logic        eol_pix;
  logic        wr_req;
  logic        ovf_event;
  logic        fifo_wr;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;
  pix_beat_t   wr_beat;
  pix_beat_t   rd_beat;

  assign sof_pix = (pixel_x == COORD_W'(VISIBLE_ORIGIN_X)) && (pixel_y == COORD_W'(VISIBLE_ORIGIN_Y));
  assign eol_pix = (pixel_x == COORD_W'(H_VISIBLE - 1));
  assign pop     = !fifo_empty && axis.tready;

  always_comb begin
    wr_beat.tuser = sof_pix;
    wr_beat.tlast = eol_pix;
    wr_beat.tdata = expand_rgb444(rgb_in);
  end

  // State register
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      state_q    <= SYNC_WAIT;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end

  // Next state: lock onto the frame origin, fall back to DROP after a loss.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SYNC_WAIT, DROP: begin
        if (wr_req) begin
          state_d = (ovf_event && DROP_TO_SOF) ? DROP : STREAM;
        end
      end
      STREAM: begin
        if (ovf_event && DROP_TO_SOF) begin
          state_d = DROP;
        end
      end
      default: state_d = SYNC_WAIT;
    endcase
  end

  // Outputs: write request, overflow detection and the sticky flag.
  always_comb begin
    wr_req     = 1'b0;
    ovf_event  = 1'b0;
    fifo_wr    = 1'b0;
    overflow_d = overflow_q;
    case (state_q)
      SYNC_WAIT, DROP: wr_req = video_on && sof_pix;
      STREAM:          wr_req = video_on;
      default:         wr_req = 1'b0;
    endcase
    ovf_event  = wr_req && fifo_full && !pop;
    fifo_wr    = wr_req && !ovf_event;
    overflow_d = overflow_q || ovf_event;
  end

  axis_sync_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (pixel_clk),
    .rst     (reset),
    .wr_en   (fifo_wr),
    .wr_data (wr_beat),
    .rd_en   (pop),
    .rd_data (rd_beat),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign axis.tvalid = !fifo_empty;
  assign axis.tdata  = rd_beat.tdata;
  assign axis.tuser  = rd_beat.tuser;
  assign axis.tlast  = rd_beat.tlast;
  assign overflow    = overflow_q;

endmodule

// File: doc/vga_axis_packer.md
VGA_AXIS_PACKER -- requirements
Module: vga_axis_packer

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, sets FIFO entry count (power of two, 4..64).
REQ-002 Parameter DROP_TO_SOF, default 1; 1 = discard the rest of a frame after an overflow.
REQ-003 Port pixel_clk  in  1  sole clock; all logic is on its rising edge.
REQ-004 Port reset  in  1  synchronous, active-high reset.
REQ-005 Port pixel_x  in  10  current column from the display timing generator.
REQ-006 Port pixel_y  in  10  current row from the display timing generator.
REQ-007 Port video_on  in  1  high when (pixel_x, pixel_y) is in the visible area.
REQ-008 Port rgb_in  in  12  {R4,G4,B4} colour for the current pixel.
REQ-009 Port tdata  out  24  AXI4-Stream video data {R8,B8,G8}.
REQ-010 Port tvalid  out  1  AXI4-Stream valid.
REQ-011 Port tready  in  1  AXI4-Stream ready from the downstream video output IP.
REQ-012 Port tuser  out  1  start of frame; marks pixel (0,0).
REQ-013 Port tlast  out  1  end of line; marks pixel x = h_visible-1.
REQ-014 Port overflow  out  1  sticky flag: at least one pixel was lost.
REQ-015 Port fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-016 Colour expansion: each 4-bit channel c becomes the 8-bit value {c,c}; tdata[23:16]=R, [15:8]=B, [7:0]=G.
REQ-017 Write request when video_on=1 and the state is STREAM.
- REQ-018 Each FIFO entry carries the 24-bit data, the tuser bit (pixel_x==visible_origin_x && pixel_y==visible_origin_y) and the tlast bit (pixel_x==h_visible-1).
REQ-019 State machine has three states.
- SYNC_WAIT: the reset state; a start-of-frame pixel with video_on=1 moves to STREAM and that pixel is written.
- STREAM: normal operation; pixels are written.
- DROP: entered on overflow when DROP_TO_SOF=1; nothing is written; the next start-of-frame pixel moves to STREAM and that pixel is written.
REQ-020 Overflow event: a write request while the FIFO is full and no read happens in the same cycle.
- The pixel is discarded and overflow is set until reset.
- With DROP_TO_SOF=1 the state goes to DROP; with DROP_TO_SOF=0 it stays in STREAM.
REQ-021 Full with a simultaneous read (tvalid&&tready): the write is accepted and fifo_level is unchanged.
REQ-022 tvalid = FIFO not empty; tdata, tuser and tlast are taken from the head entry (show-ahead) and stay stable while tvalid&&!tready.
REQ-023 Latency: a pixel written at rising edge N is presented on tvalid/tdata at edge N+1 when the FIFO was empty; there is no combinational path from inputs to outputs.
REQ-024 Pop when tvalid&&tready; a pop from an empty FIFO is impossible because tvalid=0.
REQ-025 fifo_level changes as follows: +1 on write only, -1 on read only, unchanged on both; it never exceeds FIFO_DEPTH.
REQ-026 Read and write pointers wrap modulo FIFO_DEPTH.

Reset
REQ-027 While reset=1: state=SYNC_WAIT, FIFO empty, tvalid=0, tuser=0, tlast=0, tdata=0, overflow=0, fifo_level=0.
REQ-028 Reset asserted mid-frame flushes the FIFO; streaming resumes only at the next start-of-frame pixel.

Structure
REQ-029 starsoc_params holds h_visible (640), v_visible (480), visible_origin_x/y (0), the state enum type pack_state_t, and the 24-bit AXIS pixel width constant.
REQ-030 Storage is one sub-module, axis_sync_fifo (parameterised width and depth, show-ahead, with a level output); the FSM, colour expansion and tuser/tlast tagging stay in vga_axis_packer.

Verification
REQ-031 Reset, then drive a full 640x480 frame with tready=1 -> exactly 307200 beats, 480 tlast beats, one tuser beat on the first beat, overflow=0.
REQ-032 rgb_in=12'hA5C at (0,0) -> first beat has tdata=24'hAACC55 and tuser=1.
REQ-033 Frame starts mid-way (first pixel seen is y=100) -> no beats until the next (0,0); the first beat has tuser=1.
REQ-034 Hold tready=0 for 20 cycles of visible pixels, FIFO_DEPTH=16 -> fifo_level reaches 16, overflow=1, no beats until the next frame's tuser, and the 16 stored beats are emitted intact.
REQ-035 FIFO full with tready=1 on the same cycle as a write -> write accepted, fifo_level stays 16, overflow stays 0.
REQ-036 Assert reset for one cycle at pixel (300,200) -> tvalid=0 on the next cycle, fifo_level=0, and output restarts with tuser at the next (0,0).
